// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over a ready handshake, and resolves the next PC.
// Optional misaligned-target halt is compiled in with `define IFU_ALIGN_CHECK_EN.
module ifu_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr,
   output logic             instr_valid,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   input  logic             stall,
   input  logic             npc_sel,
   input  logic             j_ctl,
   input  logic             jr_ctl,
   input  logic             bltzal,
   input  logic             zero,
   input  logic             positive,
   input  logic [15:0]      imm16,
   input  logic [25:0]      jidx26,
   input  logic [31:0]      rs_data,
   output logic [CNT_W-1:0] instr_count,
   output logic             fetch_err
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_EXEC  = 1'b1
   } state_t;

   state_t           r_state;
   logic [31:0]      r_pc;
   logic [31:0]      r_instr;
   logic             r_instr_valid;
   logic             r_imem_req;
   logic             r_fetch_err;
   logic [CNT_W-1:0] r_count;

   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_br_off;
   logic [31:0]      w_br_target;
   logic [31:0]      w_npc;
   logic             w_br_taken;
   logic             w_misaligned;

   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_br_off    = {{14{imm16[15]}}, imm16, 2'b00};
   assign w_br_target = w_pc_plus4 + w_br_off;

   // Next-PC priority: jr, then j/jal, then conditional branch, else sequential.
   always_comb begin
      w_br_taken = 1'b0;
      w_npc      = w_pc_plus4;
      if (bltzal) begin
         w_br_taken = !positive && !zero;
      end else begin
         w_br_taken = zero;
      end
      if (jr_ctl) begin
         w_npc = rs_data;
      end else if (j_ctl) begin
         w_npc = {w_pc_plus4[31:28], jidx26, 2'b00};
      end else if (npc_sel && w_br_taken) begin
         w_npc = w_br_target;
      end
   end

`ifdef IFU_ALIGN_CHECK_EN
   assign w_misaligned = (w_npc[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   // FETCH raises the request once, then waits for ready; EXEC retires on the first unstalled edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_instr_valid <= 1'b0;
         r_imem_req    <= 1'b0;
         r_fetch_err   <= 1'b0;
         r_count       <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!r_imem_req) begin
                  if (!r_fetch_err) begin
                     r_imem_req <= 1'b1;
                  end
               end else if (imem_ready) begin
                  r_instr       <= imem_rdata;
                  r_instr_valid <= 1'b1;
                  r_imem_req    <= 1'b0;
                  r_state       <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (!stall) begin
                  r_pc          <= w_npc;
                  r_instr_valid <= 1'b0;
                  r_state       <= S_FETCH;
                  r_count       <= r_count + CNT_W'(1);
                  // A misaligned target leaves the request low and halts until reset.
                  r_imem_req    <= !w_misaligned;
                  if (w_misaligned) begin
                     r_fetch_err <= 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign imem_req    = r_imem_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign instr_count = r_count;
   assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Scoreboard bench for ifu_fetch_unit: a driver plays memory and controller from a directed table,
// a monitor pops expected instructions on every EXEC entry.
module tb_ifu_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        stall;
   logic        npc_sel;
   logic        j_ctl;
   logic        jr_ctl;
   logic        bltzal;
   logic        zero;
   logic        positive;
   logic [15:0] imm16;
   logic [25:0] jidx26;
   logic [31:0] rs_data;
   logic [31:0] instr_count;
   logic        fetch_err;

   ifu_fetch_unit #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
      .stall(stall), .npc_sel(npc_sel), .j_ctl(j_ctl), .jr_ctl(jr_ctl), .bltzal(bltzal),
      .zero(zero), .positive(positive), .imm16(imm16), .jidx26(jidx26), .rs_data(rs_data),
      .instr_count(instr_count), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
      int          wait_c;
      int          stall_c;
      logic        sel, j, jr, bal, z, p;
      logic [15:0] imm;
      logic [25:0] jidx;
      logic [31:0] rs;
      int          cnt;
      int          gap;
      bit          rst;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          cnt;
      int          gap;
   } exp_t;

   localparam int unsigned NV = 19;
   vec_t vt [NV];
   vec_t v;
   exp_t q [$];
   exp_t cur;
   exp_t e;

   int n_cmp = 0;
   int n_err = 0;
   bit drv_done = 1'b0;
   logic rst_at_edge = 1'b1;

   always @(posedge clk) rst_at_edge <= reset;

   function automatic vec_t mk(input logic [31:0] a_pc, input logic [31:0] a_word,
                               input int a_wt, input int a_st,
                               input logic a_sel, input logic a_j, input logic a_jr, input logic a_bal,
                               input logic a_z, input logic a_p, input logic [15:0] a_imm,
                               input logic [25:0] a_jidx, input logic [31:0] a_rs,
                               input int a_cnt, input int a_gap, input bit a_rst);
      vec_t r;
      r.pc = a_pc; r.word = a_word; r.wait_c = a_wt; r.stall_c = a_st;
      r.sel = a_sel; r.j = a_j; r.jr = a_jr; r.bal = a_bal; r.z = a_z; r.p = a_p;
      r.imm = a_imm; r.jidx = a_jidx; r.rs = a_rs; r.cnt = a_cnt; r.gap = a_gap; r.rst = a_rst;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Directed table; exp pc of entry k+1 is the hand-computed next PC of entry k.
   initial begin
      //          pc            word          wt st sel  j    jr   bal  z    p    imm       jidx        rs            cnt gap rst
      vt[0]  = mk(32'h0000_3000, 32'h0022_1821, 0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0,         0, 0, 1'b1);
      vt[1]  = mk(32'h0000_3004, 32'h0043_2021, 0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0,         1, 2, 1'b0);
      vt[2]  = mk(32'h0000_3008, 32'h0064_2821, 0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0,         2, 2, 1'b0);
      vt[3]  = mk(32'h0000_300C, 32'h0085_3021, 2, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0,         3, 4, 1'b0);
      vt[4]  = mk(32'h0000_3010, 32'h0800_0C10, 0, 0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0000C10,32'h0,        4, 2, 1'b0);
      vt[5]  = mk(32'h0000_3040, 32'h03E0_0008, 0, 0, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,16'h0000,26'h0000C10,32'h0000_3100,5, 2, 1'b0);
      vt[6]  = mk(32'h0000_3100, 32'h03E0_0008, 0, 0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0000_3000, 6, 2, 1'b0);
      vt[7]  = mk(32'h0000_3000, 32'h1000_FFFF, 0, 0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,16'hFFFF,26'h0,     32'h0,         7, 2, 1'b0);
      vt[8]  = mk(32'h0000_3000, 32'h1000_FFFF, 0, 0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,16'hFFFF,26'h0,     32'h0,         8, 2, 1'b0);
      vt[9]  = mk(32'h0000_3004, 32'h03E0_0008, 0, 0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0000_3000, 9, 2, 1'b0);
      vt[10] = mk(32'h0000_3000, 32'h0410_0004, 0, 0, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0004,26'h0,     32'h0,        10, 2, 1'b0);
      vt[11] = mk(32'h0000_3014, 32'h03E0_0008, 0, 0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0000_3000,11, 2, 1'b0);
      vt[12] = mk(32'h0000_3000, 32'h0410_0004, 0, 3, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,16'h0004,26'h0,     32'h0,        12, 2, 1'b0);
      vt[13] = mk(32'h0000_3004, 32'h0410_0004, 0, 0, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,16'h0004,26'h0,     32'h0,        13, 5, 1'b0);
      vt[14] = mk(32'h0000_3008, 32'h03E0_0008, 1, 0, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'hFFFF_FFFC,14, 3, 1'b0);
      vt[15] = mk(32'hFFFF_FFFC, 32'h0000_0000, 0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0,        15, 2, 1'b0);
      vt[16] = mk(32'h0000_0000, 32'h0410_FFFF, 0, 0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,16'hFFFF,26'h0,     32'h0,        16, 2, 1'b0);
      vt[17] = mk(32'h0000_3000, 32'h00A6_3821, 0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0,         0, 0, 1'b1);
      vt[18] = mk(32'h0000_3004, 32'h00C7_4021, 0, 0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,26'h0,     32'h0,         1, 2, 1'b0);
   end

   // Driver: plays instruction memory and controller, pushes the expected instruction per vector.
   initial begin
      reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
      npc_sel = 1'b0; j_ctl = 1'b0; jr_ctl = 1'b0; bltzal = 1'b0; zero = 1'b0; positive = 1'b0;
      imm16 = 16'h0; jidx26 = 26'h0; rs_data = 32'h0;
      @(negedge clk);
      for (int k = 0; k < int'(NV); k++) begin
         v = vt[k];
         if (v.rst) begin
            // Reset lands on a cycle where memory claims ready; that data must be dropped.
            imem_ready = 1'b1; imem_rdata = 32'hBAD0_0BAD; reset = 1'b1;
            @(negedge clk);
            reset = 1'b0; imem_ready = 1'b0;
         end
         e.pc = v.pc; e.instr = v.word; e.cnt = v.cnt; e.gap = v.gap;
         q.push_back(e);
         for (int n = 0; n < 50 && !imem_req; n++) @(negedge clk);
         repeat (v.wait_c) begin
            imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
         end
         imem_ready = 1'b1; imem_rdata = v.word;
         npc_sel = v.sel; j_ctl = v.j; jr_ctl = v.jr; bltzal = v.bal;
         zero = v.z; positive = v.p; imm16 = v.imm; jidx26 = v.jidx; rs_data = v.rs;
         stall = (v.stall_c != 0);
         @(negedge clk);
         imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
         repeat (v.stall_c) @(negedge clk);
         stall = 1'b0;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      drv_done = 1'b1;
   end

   // Monitor: reset-state checks, address stability, EXEC-entry pops, stall hold and a watchdog.
   initial begin
      int  cyc;
      int  last_entry;
      int  idle;
      bit  prev_valid;
      cyc = 0; last_entry = 0; idle = 0; prev_valid = 1'b0;
      while (!drv_done) begin
         @(negedge clk);
         cyc++;
         if (rst_at_edge) begin
            chk("rst_pc", pc, 32'h0000_3000);
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_instr_valid", 32'(instr_valid), 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_count", instr_count, 32'd0);
            chk("rst_fetch_err", 32'(fetch_err), 32'd0);
            idle = 0;
         end else begin
            if (imem_req && q.size() != 0) chk("imem_addr", imem_addr, q[0].pc);
            if (instr_valid && !prev_valid) begin
               idle = 0;
               if (q.size() == 0) begin
                  chk("exec_unexpected", 32'(instr_valid), 32'd0);
               end else begin
                  cur = q.pop_front();
                  chk("exec_pc", pc, cur.pc);
                  chk("exec_instr", instr, cur.instr);
                  chk("exec_count", instr_count, 32'(cur.cnt));
                  chk("exec_pc_plus4", pc_plus4, cur.pc + 32'd4);
                  chk("exec_imem_req", 32'(imem_req), 32'd0);
                  chk("exec_fetch_err", 32'(fetch_err), 32'd0);
                  if (cur.gap != 0) chk("exec_gap", 32'(cyc - last_entry), 32'(cur.gap));
                  last_entry = cyc;
               end
            end else if (instr_valid) begin
               chk("hold_pc", pc, cur.pc);
               chk("hold_instr", instr, cur.instr);
               chk("hold_count", instr_count, 32'(cur.cnt));
            end else begin
               idle++;
               if (idle == 40) chk("watchdog_idle", 32'(idle), 32'd0);
            end
         end
         prev_valid = instr_valid;
      end
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
